// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front-end
package fetch_pkg;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - pointer-based prefetch FIFO of {pc, inst} entries with registered count
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_push,
    input  fetch_entry_t                     i_push_data,
    input  logic                             i_pop,
    input  logic                             i_flush,
    output logic [$clog2(DEPTH+1)-1:0]       o_count,
    output logic                             o_full,
    output logic                             o_empty,
    output fetch_entry_t                     o_head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t    r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    // Storage carries no reset; the head is qualified by o_empty downstream.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, credit-limited imem requests, flushable prefetch; FETCH_PERF_EN adds perf counters
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4,
    output logic        misalign_alert
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushes,
    output logic [31:0] perf_drops
`endif
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = CW + 2;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_ret_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;
    logic          r_misalign;

    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    fetch_entry_t  w_head;
    logic [SW-1:0] w_credit_sum;
    logic [SW-1:0] w_redir_drop;
    logic          w_req_hs;
    logic          w_in_flight;
    logic          w_rsp_drop;
    logic          w_push;
    logic          w_pop;

    assign w_credit_sum   = SW'(r_outstanding) + SW'(r_drop) + SW'(w_count);
    assign imem_req_valid = rst && (w_credit_sum < SW'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_hs       = imem_req_valid && imem_req_ready;

    assign w_in_flight = (r_outstanding != '0) || (r_drop != '0);
    assign w_rsp_drop  = imem_rsp_valid && !redirect_valid && (r_drop != '0);
    assign w_push      = imem_rsp_valid && !redirect_valid && (r_drop == '0) && (r_outstanding != '0);
    assign w_pop       = !w_empty && inst_ready && !redirect_valid;

    // A response consumed in the redirect cycle belongs to the in-flight set, so it leaves the drop tally.
    assign w_redir_drop = SW'(r_drop) + SW'(r_outstanding) + SW'(w_req_hs)
                        - SW'(imem_rsp_valid && w_in_flight);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_ret_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_misalign    <= 1'b0;
        end else begin
            r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                r_fetch_pc    <= {redirect_pc[31:2], 2'b00};
                r_ret_pc      <= {redirect_pc[31:2], 2'b00};
                r_outstanding <= '0;
                r_drop        <= w_redir_drop[CW-1:0];
            end else begin
                if (w_req_hs) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push)   r_ret_pc   <= r_ret_pc + 32'd4;
                r_outstanding <= r_outstanding + CW'(w_req_hs) - CW'(w_push);
                r_drop        <= r_drop - CW'(w_rsp_drop);
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ('{pc: r_ret_pc, inst: imem_rsp_data}),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head)
    );

    assign inst_valid     = !w_empty;
    assign inst           = inst_valid ? w_head.inst : INST_NOP;
    assign inst_pc        = inst_valid ? w_head.pc : 32'd0;
    assign inst_pc_plus4  = inst_pc + 32'd4;
    assign misalign_alert = r_misalign;

    a_rsp_in_protocol: assert property (@(posedge clk) disable iff (!rst)
        !(imem_rsp_valid && !w_in_flight));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_push && w_full && !w_pop));

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushes;
    logic [31:0] r_perf_drops;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_fetched <= '0;
            r_perf_flushes <= '0;
            r_perf_drops   <= '0;
        end else begin
            if (w_pop)          r_perf_fetched <= r_perf_fetched + 32'd1;
            if (redirect_valid) r_perf_flushes <= r_perf_flushes + 32'd1;
            if (w_rsp_drop || (redirect_valid && imem_rsp_valid && w_in_flight))
                r_perf_drops <= r_perf_drops + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushes = r_perf_flushes;
    assign perf_drops   = r_perf_drops;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit with an in-order latency-1 memory model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;
    logic        misalign_alert;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushes;
    logic [31:0] perf_drops;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic rsp_hold = 1'b0;
    logic [31:0] pend[$];
    logic [31:0] hs_log[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pc_plus4  (inst_pc_plus4),
        .misalign_alert (misalign_alert)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushes   (perf_flushes),
        .perf_drops     (perf_drops)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic tick();
        #1;
        if (imem_req_valid && imem_req_ready) begin
            pend.push_back(imem_req_addr);
            hs_log.push_back(imem_req_addr);
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
            got_pc.push_back(inst_pc);
            got_inst.push_back(inst);
        end
        @(posedge clk);
        @(negedge clk);
        if (!rsp_hold && pend.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        rsp_hold = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        pend.delete();
        hs_log.delete();
        got_pc.delete();
        got_inst.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_got(input int n, input string tag);
        int k = 0;
        while (got_pc.size() < n && k < 30) begin
            tick();
            k++;
        end
        check({tag, "_timeout"}, 32'(got_pc.size() >= n), 32'd1);
    endtask

    initial begin
        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_nop", inst, 32'h0000_0013);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_misalign", 32'(misalign_alert), 32'd0);

        // streaming, L=1
        do_reset();
        tick();
        check("t1_valid_after_hs", 32'(inst_valid), 32'd0);
        tick();
        check("t1_first_valid", 32'(inst_valid), 32'd1);
        check("t1_first_pc", inst_pc, 32'h0);
        check("t1_first_inst", inst, mem_word(32'h0));
        check("t1_pc_plus4", inst_pc_plus4, 32'h4);
        repeat (6) tick();
        check("t1_hs_count", 32'(hs_log.size()), 32'd8);
        check("t1_hs1", hs_log[1], 32'h4);
        check("t1_hs2", hs_log[2], 32'h8);
        check("t1_pop_count", 32'(got_pc.size()), 32'd6);
        for (int i = 0; i < 6 && i < got_pc.size(); i++) begin
            check("t1_pop_pc", got_pc[i], 32'(4 * i));
            check("t1_pop_inst", got_inst[i], mem_word(32'(4 * i)));
        end

        // decode stalled: credit limit
        do_reset();
        inst_ready = 1'b0;
        repeat (10) tick();
        check("t2_hs_count", 32'(hs_log.size()), 32'd4);
        check("t2_req_valid_off", 32'(imem_req_valid), 32'd0);
        check("t2_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        wait_got(5, "t2");
        for (int i = 0; i < 5 && i < got_pc.size(); i++)
            check("t2_drain_pc", got_pc[i], 32'(4 * i));
        check("t2_restart_addr", hs_log[4], 32'h10);

        // memory back-pressure
        do_reset();
        tick();
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold_valid", 32'(imem_req_valid), 32'd1);
            check("t3_hold_addr", imem_req_addr, 32'h8);
        end
        check("t3_no_advance", 32'(hs_log.size()), 32'd2);
        imem_req_ready = 1'b1;
        tick();
        check("t3_resume_addr", hs_log[2], 32'h8);

        // redirect with two in flight plus a same-cycle handshake
        do_reset();
        rsp_hold = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        rsp_hold = 1'b0;
        check("t4_hs_at_redirect", hs_log[2], 32'h8);
        wait_got(1, "t4");
        check("t4_first_pc", got_pc[0], 32'h100);
        check("t4_first_inst", got_inst[0], mem_word(32'h100));
        check("t4_new_req", hs_log[3], 32'h100);

        // redirect coinciding with a response and a pop
        do_reset();
        tick();
        tick();
        check("t5_pre_rsp", 32'(imem_rsp_valid), 32'd1);
        check("t5_pre_valid", 32'(inst_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check("t5_flushed", 32'(inst_valid), 32'd0);
        wait_got(1, "t5");
        check("t5_first_pc", got_pc[0], 32'h200);
        check("t5_first_inst", got_inst[0], mem_word(32'h200));

        // misaligned redirect, then PC wrap
        do_reset();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        check("t6_misalign_hi", 32'(misalign_alert), 32'd1);
        check("t6_req_addr", imem_req_addr, 32'h100);
`ifdef FETCH_PERF_EN
        check("t6_perf_flushes", perf_flushes, 32'd1);
`endif
        tick();
        check("t6_misalign_lo", 32'(misalign_alert), 32'd0);
        inst_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 20 && !inst_valid; k++) tick();
        check("t6_wrap_pc", inst_pc, 32'hFFFF_FFFC);
        check("t6_wrap_plus4", inst_pc_plus4, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front-end sitting directly upstream of the decode stage (control unit, register file, immediate extender).
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned words with their PCs in a small prefetch FIFO and hands them to decode over a valid/ready channel.
- Accepts redirects from execute (taken branch, JAL, JALR) and flushes wrong-path words, including responses still in flight.

Parameters:
- DEPTH, 4, prefetch FIFO entries; also the credit limit for outstanding plus buffered words (power of 2, at least 2).
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  instruction memory accepts the request.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response valid; in order, at least 1 cycle after the accepting handshake, always accepted.
- imem_rsp_data  input  32  returned instruction word.
- redirect_valid  input  1  single-cycle redirect request.
- redirect_pc  input  32  redirect target.
- inst_valid  output  1  decode-side word valid.
- inst_ready  input  1  decode consumes the word.
- inst  output  32  instruction; NOP 32'h0000_0013 when inst_valid=0.
- inst_pc  output  32  PC of inst.
- inst_pc_plus4  output  32  inst_pc+4, mod 2^32.
- misalign_alert  output  1  registered one-cycle pulse: last redirect_pc[1:0] was nonzero.

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop=0.
  - imem_req_valid=0, inst_valid=0, inst=NOP, inst_pc=0, misalign_alert=0.
- Counter widths: $clog2(DEPTH+1) bits.
- Request issue:
  - imem_req_valid=1 when outstanding + drop + fifo_count < DEPTH.
  - imem_req_addr = fetch_pc, held stable while valid and not ready.
  - On handshake: fetch_pc += 4 (wraps mod 2^32); outstanding++.
  - First request is asserted on the first cycle after reset deassertion.
- Response handling:
  - If drop>0: discard the word; drop--.
  - Otherwise: push {pc, data} into the FIFO; outstanding--.
  - pc is taken from a return-PC register that advances by 4 per accepted response.
  - A response with outstanding=drop=0 is a protocol violation: ignore it and flag it with an assertion.
- Decode side:
  - inst_valid = FIFO not empty; inst, inst_pc, inst_pc_plus4 come from the FIFO head (combinational from storage).
  - Pop on inst_valid && inst_ready.
  - Simultaneous push and pop when full is legal; the credit rule makes overflow impossible.
- Redirect (highest priority) takes effect at the clock edge:
  - FIFO cleared; any same-cycle pop or push is discarded.
  - drop = drop + outstanding, plus 1 if a request handshake occurs in the same cycle; outstanding=0.
  - A response arriving in the same cycle is discarded.
  - fetch_pc and return-PC are set to {redirect_pc[31:2], 2'b00}.
  - misalign_alert = |redirect_pc[1:0] on the next cycle.
  - The first new request issues on the cycle after the redirect.
  - Back-to-back redirects: the latest one wins; drop keeps accumulating.
- Latency:
  - Memory latency L gives inst_valid at L+1 cycles after the request handshake (1 cycle for FIFO write).
  - Redirect-to-first-valid = L+2 cycles.
- Reset mid-operation clears everything; responses from before reset are outside protocol.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched[31:0] (accepted decode pops) and perf_flushes[31:0] (redirects).
  - Both wrap mod 2^32 and reset to 0.
  - Adds perf_drops[31:0] (discarded responses).
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - INST_NOP = 32'h0000_0013.
  - DEFAULT_RESET_PC.
  - typedef fetch_entry_t struct {pc[31:0], inst[31:0]}.
- Sub-module fetch_fifo:
  - Parameterised on DEPTH, entries of fetch_entry_t.
  - Ports: push/pop/flush, count, full/empty, head.
  - Pointer-based with wrap-around and registered count.

Test Plan:
- Release reset with imem_req_ready=1, L=1, inst_ready=1 -> addresses 0x0, 0x4, 0x8 on consecutive cycles; first inst_valid 2 cycles after the first handshake with inst_pc=0x0; one word per cycle thereafter.
- inst_ready=0, DEPTH=4 -> exactly 4 request handshakes, then imem_req_valid=0; raising inst_ready drains 0x0..0xC in order and restarts at 0x10.
- imem_req_ready=0 for 3 cycles -> imem_req_addr held at 0x8 with valid=1; no PC advance.
- Redirect to 0x100 with 2 responses in flight and a same-cycle request handshake -> the next 3 responses are dropped; the next inst_pc is 0x100 with inst equal to memory[0x100].
- Redirect in the same cycle as a response arrival and an inst pop -> FIFO empty next cycle, response discarded, no stale word reaches decode.
- Redirect to 0x102 -> misalign_alert=1 for exactly one cycle; fetch resumes at 0x100. With FETCH_PERF_EN, perf_flushes increments by 1.
